// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite control register block: response codes,
// register indices and the byte-strobe expansion helper.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int REG_ID     = 0;
    localparam int REG_CYCLES = 1;
    localparam int REG_STATUS = 2;
    localparam int REG_RSVD   = 3;
    localparam int REG_CTRL   = 4;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite slave register file: ID, free-running cycle counter, sticky W1C status
// and scratch/control words, with reg 4 mirrored onto CTRL_OUT.
module axil_ctrl_regs #(
    parameter int          NREGS     = 16,
    parameter logic [31:0] ID_VALUE  = 32'h0C91_0001,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    input  logic [31:0] STATUS_SET,
    output logic [31:0] CTRL_OUT
);
    import axil_pkg::*;

    localparam int IDX_W = $clog2(NREGS);

    function automatic logic in_range(input logic [31:0] addr);
        return addr[31:2+IDX_W] == ADDR_BASE[31:2+IDX_W];
    endfunction

    logic              ready_q;
    logic              aw_held_q, aw_held_d;
    logic [31:0]       aw_addr_q, aw_addr_d;
    logic              w_held_q,  w_held_d;
    logic [31:0]       w_data_q,  w_data_d;
    logic [3:0]        w_strb_q,  w_strb_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;
    logic              rvalid_q,  rvalid_d;
    logic [1:0]        rresp_q,   rresp_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [31:0]       cycles_q,  cycles_d;
    logic [31:0]       status_q,  status_d;
    logic [31:0]       ctrl_q,    ctrl_d;
    logic [31:0]       scratch_q [NREGS];
    logic [31:0]       scratch_d [NREGS];

    logic              aw_hs, w_hs, ar_hs, wr_commit;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [31:0]       wmask, status_clr;
    logic              unused_bits;

    assign S_AXI_AWREADY = ready_q && !ARESET && !aw_held_q && !bvalid_q;
    assign S_AXI_WREADY  = ready_q && !ARESET && !w_held_q && !bvalid_q;
    assign S_AXI_ARREADY = ready_q && !ARESET && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign CTRL_OUT      = ctrl_q;

    assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
    assign wr_commit = aw_held_q && w_held_q;
    assign wr_idx    = aw_addr_q[2 +: IDX_W];
    assign rd_idx    = S_AXI_ARADDR[2 +: IDX_W];
    assign wmask     = strb_mask(w_strb_q);

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr_q[1:0], S_AXI_ARADDR[1:0]};

    // NOTE: every variable gets its hold value first so no path through this block
    // leaves one unassigned; that is what keeps it purely combinational.
    always_comb begin
        aw_held_d  = aw_held_q;
        aw_addr_d  = aw_addr_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        scratch_d  = scratch_q;
        status_clr = '0;
        cycles_d   = cycles_q + 32'd1;
        ctrl_d     = scratch_q[REG_CTRL];

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = S_AXI_AWADDR;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (wr_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (!in_range(aw_addr_q)) begin
                bresp_d = RESP_DECERR;
            end else begin
                case (int'(wr_idx))
                    REG_ID, REG_CYCLES, REG_RSVD: bresp_d = RESP_SLVERR;
                    REG_STATUS: begin
                        bresp_d    = RESP_OKAY;
                        status_clr = w_data_q & wmask;
                    end
                    default: begin
                        bresp_d           = RESP_OKAY;
                        scratch_d[wr_idx] = (scratch_q[wr_idx] & ~wmask) | (w_data_q & wmask);
                    end
                endcase
            end
        end

        // Set wins over a same-cycle clear of the same bit.
        status_d = (status_q & ~status_clr) | STATUS_SET;

        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        // Reads sample the current state, so a coincident commit is not yet visible.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (!in_range(S_AXI_ARADDR)) begin
                rresp_d = RESP_DECERR;
                rdata_d = '0;
            end else begin
                rresp_d = RESP_OKAY;
                case (int'(rd_idx))
                    REG_ID:     rdata_d = ID_VALUE;
                    REG_CYCLES: rdata_d = cycles_q;
                    REG_STATUS: rdata_d = status_q;
                    REG_RSVD:   rdata_d = '0;
                    default:    rdata_d = scratch_q[rd_idx];
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ready_q   <= 1'b0;
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            cycles_q  <= '0;
            status_q  <= '0;
            ctrl_q    <= '0;
            // NOTE: the scratch array is cleared word by word because software relies
            // on zeroed control words after reset; this keeps it in flops, not RAM.
            for (int i = 0; i < NREGS; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            ready_q   <= 1'b1;
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            cycles_q  <= cycles_d;
            status_q  <= status_d;
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
        end
    end

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Directed bench for axil_ctrl_regs: hand-computed vectors checked with immediate
// assertions; inputs change and outputs are sampled on the falling clock edge.
module tb_axil_ctrl_regs;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] STATUS_SET;
    logic [31:0] CTRL_OUT;

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    axil_ctrl_regs #(
        .NREGS     (16),
        .ID_VALUE  (32'h0C91_0001),
        .ADDR_BASE (32'h0000_0000)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .STATUS_SET    (STATUS_SET),
        .CTRL_OUT      (CTRL_OUT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
    endtask

    // Single read; also checks that RVALID follows the handshake by exactly one cycle.
    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        n = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && n < 20) begin
            tick();
            n++;
        end
        check("ar_accept_timeout", n < 20, 1'b1);
        tick();
        S_AXI_ARVALID = 1'b0;
        check("rvalid_latency", S_AXI_RVALID, 1'b1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    // AW and W presented together; lat counts cycles from acceptance to BVALID.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output int lat);
        int  n;
        logic aw_acc, w_acc;
        n = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
            aw_acc = S_AXI_AWVALID && S_AXI_AWREADY;
            w_acc  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_acc) S_AXI_AWVALID = 1'b0;
            if (w_acc)  S_AXI_WVALID  = 1'b0;
            n++;
        end
        check("aw_w_accept_timeout", n < 20, 1'b1);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        lat = 0;
        while (!S_AXI_BVALID && lat < 20) begin
            tick();
            lat++;
        end
        check("bvalid_timeout", lat < 20, 1'b1);
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, c1, c2;
        logic [1:0]  rr, br;
        int          lat, n;

        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        STATUS_SET = '0;

        // 1: reset state and ID read
        repeat (3) tick();
        check("rst_awready", S_AXI_AWREADY, 1'b0);
        check("rst_arready", S_AXI_ARREADY, 1'b0);
        check("rst_bvalid", S_AXI_BVALID, 1'b0);
        check("rst_rvalid", S_AXI_RVALID, 1'b0);
        check("rst_rdata", S_AXI_RDATA, 32'h0);
        check("rst_ctrl_out", CTRL_OUT, 32'h0);
        ARESET = 1'b0;
        tick();
        check("post_rst_awready", S_AXI_AWREADY, 1'b1);
        check("post_rst_wready", S_AXI_WREADY, 1'b1);
        check("post_rst_arready", S_AXI_ARREADY, 1'b1);
        axi_read(32'h0, rd, rr);
        check("id_rdata", rd, 32'h0C91_0001);
        check("id_rresp", rr, 2'b00);

        // 2: strobed write to reg 4, readback and CTRL_OUT
        axi_write(32'h10, 32'hA5A5_1234, 4'b0101, br, lat);
        check("reg4_bresp", br, 2'b00);
        check("same_cycle_b_latency", lat, 1);
        axi_read(32'h10, rd, rr);
        check("reg4_rdata", rd, 32'h00A5_0034);
        check("reg4_rresp", rr, 2'b00);
        check("ctrl_out_reg4", CTRL_OUT, 32'h00A5_0034);

        // 3: W three cycles ahead of AW, BREADY held off, second AW blocked
        S_AXI_WDATA = 32'h1122_3344; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        check("w_held_blocks_wready", S_AXI_WREADY, 1'b0);
        check("w_only_no_bvalid", S_AXI_BVALID, 1'b0);
        repeat (2) tick();
        S_AXI_AWADDR = 32'h14; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWADDR = 32'h18;
        check("aw_held_blocks_awready", S_AXI_AWREADY, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bvalid_held", S_AXI_BVALID, 1'b1);
            check("bresp_stable", S_AXI_BRESP, 2'b00);
            check("awready_blocked_by_b", S_AXI_AWREADY, 1'b0);
            tick();
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("bvalid_cleared", S_AXI_BVALID, 1'b0);
        check("awready_after_b", S_AXI_AWREADY, 1'b1);
        axi_write(32'h18, 32'hCAFE_F00D, 4'hF, br, lat);
        check("reg6_bresp", br, 2'b00);
        axi_read(32'h14, rd, rr);
        check("reg5_single_commit", rd, 32'h1122_3344);
        axi_read(32'h18, rd, rr);
        check("reg6_rdata", rd, 32'hCAFE_F00D);

        // 4: read-only, reserved and out-of-range accesses
        axi_write(32'h4, 32'hFFFF_FFFF, 4'hF, br, lat);
        check("cycles_write_slverr", br, 2'b10);
        axi_read(32'h4, c1, rr);
        axi_read(32'h4, c2, rr);
        check("cycles_counting", c2 - c1, 32'd2);
        axi_write(32'h0, 32'h0, 4'hF, br, lat);
        check("id_write_slverr", br, 2'b10);
        axi_read(32'h0, rd, rr);
        check("id_unchanged", rd, 32'h0C91_0001);
        axi_write(32'hC, 32'hFFFF_FFFF, 4'hF, br, lat);
        check("rsvd_write_slverr", br, 2'b10);
        axi_read(32'hC, rd, rr);
        check("rsvd_reads_zero", rd, 32'h0);
        check("rsvd_rresp", rr, 2'b00);
        axi_read(32'h40, rd, rr);
        check("oor_rresp", rr, 2'b11);
        check("oor_rdata", rd, 32'h0);
        axi_write(32'h50, 32'hFFFF_FFFF, 4'hF, br, lat);
        check("oor_write_decerr", br, 2'b11);
        axi_read(32'h10, rd, rr);
        check("oor_write_no_alias", rd, 32'h00A5_0034);
        axi_read(32'h1000_0010, rd, rr);
        check("upper_bits_decerr", rr, 2'b11);

        // 5: sticky status, set beats clear, per-byte W1C
        STATUS_SET = 32'h1;
        tick();
        STATUS_SET = 32'h0;
        axi_read(32'h8, rd, rr);
        check("status_sticky", rd, 32'h1);
        S_AXI_AWADDR = 32'h8; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        STATUS_SET = 32'h1;
        tick();
        STATUS_SET = 32'h0;
        check("status_clr_bvalid", S_AXI_BVALID, 1'b1);
        check("status_clr_bresp", S_AXI_BRESP, 2'b00);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        axi_read(32'h8, rd, rr);
        check("status_set_wins", rd, 32'h1);
        axi_write(32'h8, 32'h1, 4'hF, br, lat);
        axi_read(32'h8, rd, rr);
        check("status_cleared", rd, 32'h0);
        STATUS_SET = 32'h0000_0101;
        tick();
        STATUS_SET = 32'h0;
        axi_write(32'h8, 32'h0000_0101, 4'b0001, br, lat);
        axi_read(32'h8, rd, rr);
        check("status_w1c_strobed", rd, 32'h0000_0100);

        // 6: reset with AW held and R pending, then normal traffic
        S_AXI_AWADDR = 32'h10; S_AXI_AWVALID = 1'b1;
        S_AXI_ARADDR = 32'h0;  S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("pre_rst_rvalid_pending", S_AXI_RVALID, 1'b1);
        ARESET = 1'b1;
        tick();
        check("mid_rst_rvalid", S_AXI_RVALID, 1'b0);
        check("mid_rst_bvalid", S_AXI_BVALID, 1'b0);
        check("mid_rst_ctrl_out", CTRL_OUT, 32'h0);
        check("mid_rst_awready", S_AXI_AWREADY, 1'b0);
        ARESET = 1'b0;
        tick();
        check("after_rst_awready", S_AXI_AWREADY, 1'b1);
        axi_read(32'h10, rd, rr);
        check("scratch4_cleared", rd, 32'h0);
        axi_read(32'h18, rd, rr);
        check("scratch6_cleared", rd, 32'h0);

        S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        repeat (2) tick();
        check("dropped_aw_no_commit", S_AXI_BVALID, 1'b0);
        S_AXI_AWADDR = 32'h14; S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 20) begin
            tick();
            n++;
        end
        tick();
        S_AXI_AWVALID = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin
            tick();
            n++;
        end
        check("late_aw_bvalid", S_AXI_BVALID, 1'b1);
        check("late_aw_bresp", S_AXI_BRESP, 2'b00);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        axi_read(32'h14, rd, rr);
        check("late_aw_rdata", rd, 32'hDEAD_BEEF);

        axi_write(32'h10, 32'h1234_5678, 4'hF, br, lat);
        check("post_rst_write_bresp", br, 2'b00);
        tick();
        check("ctrl_out_after_rst_write", CTRL_OUT, 32'h1234_5678);

        // Commit and read of reg 4 on the same edge: the read sees the old value
        S_AXI_AWADDR = 32'h10; S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = 32'h10; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        check("collide_rvalid", S_AXI_RVALID, 1'b1);
        check("collide_old_value", S_AXI_RDATA, 32'h1234_5678);
        check("collide_bvalid", S_AXI_BVALID, 1'b1);
        check("ctrl_out_not_yet", CTRL_OUT, 32'h1234_5678);
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
        check("ctrl_out_next_cycle", CTRL_OUT, 32'h0BAD_F00D);
        axi_read(32'h10, rd, rr);
        check("collide_new_value", rd, 32'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
